nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//   Sequencer that performs wide (4*NIBBLES-bit) additions by time-multiplexing
//   one 4-bit CLA slice (A,B,C_IN -> SUM,C_OUT), one nibble per clock, LSB first.
//   It registers the inter-nibble carry and assembles the result.
//   It sits between a requester (START/READY/DONE handshake) and the CLA slice.
//   The CLA slice is instantiated inside this block.
// PARAMETERS
//   NIBBLES   4   number of 4-bit slices per operand; W = 4*NIBBLES; legal range >= 1
// PORTS
//   CLK    in   1   system clock, rising edge
//   RST    in   1   asynchronous, active-high reset
//   START  in   1   request; sampled only when READY=1
//   A      in   W   operand A; captured on the accepting edge
//   B      in   W   operand B; captured on the accepting edge
//   C_IN   in   1   carry in; captured on the accepting edge
//   READY  out  1   1 when idle and able to accept START
//   BUSY   out  1   1 while an operation is in flight (RUN or FIN)
//   DONE   out  1   one-cycle pulse; SUM, C_OUT and OVF are valid from this cycle on
//   SUM    out  W   registered result; held until the next DONE
//   C_OUT  out  1   registered carry out of the MSB nibble
//   OVF    out  1   registered signed (two's complement) overflow
// BEHAVIOUR
//   FSM states: IDLE -> RUN -> FIN -> IDLE.
//   - IDLE: READY=1. When START=1 at an edge:
//       latch A and B into op regs, carry_r<=C_IN, idx<=0, go to RUN.
//   - RUN: CLA inputs are op_a[4*idx+:4], op_b[4*idx+:4] and carry_r. Each edge:
//       acc[4*idx+:4]<=SUM_slice, carry_r<=C_OUT_slice, idx<=idx+1.
//     On the edge where idx==NIBBLES-1:
//       SUM<=final acc, C_OUT<=slice carry, OVF<=(A[W-1]==B[W-1]) & (SUM[W-1]!=A[W-1]),
//       go to FIN.
//   - FIN: DONE=1 for exactly one cycle, then go to IDLE unconditionally.
//   Timing:
//   - START accepted at edge E0. Nibble k is written at edge E(k+1).
//     DONE is high for the cycle starting at edge E(NIBBLES). READY returns at edge E(NIBBLES+1).
//   - Back-to-back throughput is one operation every NIBBLES+2 cycles.
//   Output stability:
//   - SUM, C_OUT and OVF change only on the edge entering FIN.
//   - Partial results never appear on SUM.
//   Handshake and width rules:
//   - START while BUSY is ignored, not queued. A/B/C_IN changes after acceptance have no effect.
//   - idx is a counter of width $clog2(NIBBLES) (minimum 1 bit). It never wraps past NIBBLES-1.
//   - NIBBLES=1: RUN lasts one cycle; DONE is high at E1.
//   - Addition is modulo 2^W. C_OUT is the true unsigned carry.
//   - C_IN participates in the sum; it is not used for the OVF calculation.
//   Reset (async, any state, including mid-RUN):
//   - state=IDLE, READY=1, BUSY=0, DONE=0.
//   - SUM=0, C_OUT=0, OVF=0, acc=0, carry_r=0, idx=0.
//   - An aborted operation produces no DONE.
// TESTING (NIBBLES=4, W=16)
//   1. A=0x00FF, B=0x0001, C_IN=0 -> SUM=0x0100, C_OUT=0, OVF=0; DONE exactly 4 cycles after E0.
//   2. A=0xFFFF, B=0x0000, C_IN=1 -> SUM=0x0000, C_OUT=1, OVF=0 (carry ripples through all nibbles).
//   3. A=0x7FFF, B=0x0001, C_IN=0 -> SUM=0x8000, C_OUT=0, OVF=1;
//      A=0x8000, B=0x8000 -> SUM=0x0000, C_OUT=1, OVF=1.
//   4. START held high, operand pairs random -> DONE every 6 cycles;
//      each SUM equals the golden (A+B+C_IN) mod 2^16; START during BUSY ignored.
//   5. RST asserted 2 cycles into RUN -> outputs zero immediately, no DONE;
//      next START gives a correct result.
//   6. NIBBLES=1, exhaustive A,B in 0..15, C_IN in 0..1 -> SUM/C_OUT match the reference model;
//      DONE at E1.

Source files
------------

// File: rtl/nibble_serial_adder_if.sv
// Requester-side bundle for the nibble-serial adder: start/ready/done handshake,
// operands in, registered result out.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   modport master (
      output start, a, b, c_in,
      input  ready, busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, a, b, c_in,
      output ready, busy, done, sum, c_out, ovf
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by time-multiplexing one 4-bit carry-lookahead slice,
// one nibble per clock, LSB first, with registered carry and result assembly.
module nibble_serial_adder_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum of generate/propagate terms, no ripple.
   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign sum   = p ^ c[3:0];
   assign c_out = c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [3:0]       op_a [NIBBLES];
   logic [3:0]       op_b [NIBBLES];
   logic [3:0]       acc [NIBBLES];
   logic [3:0]       acc_nxt [NIBBLES];
   logic [W-1:0]     acc_final;
   logic             carry_r;
   logic [IDX_W-1:0] idx;

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_sum;
   logic             slice_carry;

   logic [W-1:0]     sum_r;
   logic             c_out_r;
   logic             ovf_r;

   logic             ready;
   logic             busy;
   logic             done;
   logic             accept;
   logic             last;

   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   assign accept = (state == IDLE) && bus.start;
   assign last   = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Nibble selection into the slice, and the accumulator as it will look after this edge.
   always_comb begin
      slice_a   = '0;
      slice_b   = '0;
      acc_final = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (idx == IDX_W'(k)) begin
            slice_a = op_a[k];
            slice_b = op_b[k];
         end
      end
      for (int k = 0; k < NIBBLES; k++) begin
         acc_nxt[k]           = (idx == IDX_W'(k)) ? slice_sum : acc[k];
         acc_final[4*k +: 4]  = acc_nxt[k];
      end
   end

   nibble_serial_adder_cla4 u_cla (
      .a     (slice_a),
      .b     (slice_b),
      .c_in  (carry_r),
      .sum   (slice_sum),
      .c_out (slice_carry)
   );

   // Result registers load only on the final nibble so SUM never shows partial values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NIBBLES; k++) begin
            op_a[k] <= '0;
            op_b[k] <= '0;
            acc[k]  <= '0;
         end
         carry_r <= 1'b0;
         idx     <= '0;
         sum_r   <= '0;
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept) begin
         for (int k = 0; k < NIBBLES; k++) begin
            op_a[k] <= bus.a[4*k +: 4];
            op_b[k] <= bus.b[4*k +: 4];
         end
         carry_r <= bus.c_in;
         idx     <= '0;
      end else if (state == RUN) begin
         for (int k = 0; k < NIBBLES; k++) begin
            acc[k] <= acc_nxt[k];
         end
         carry_r <= slice_carry;
         if (last) begin
            idx     <= '0;
            sum_r   <= acc_final;
            c_out_r <= slice_carry;
            ovf_r   <= signed_ovf(op_a[NIBBLES-1][3], op_b[NIBBLES-1][3], acc_final[W-1]);
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   assign bus.ready = ready;
   assign bus.busy  = busy;
   assign bus.done  = done;
   assign bus.sum   = sum_r;
   assign bus.c_out = c_out_r;
   assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: a 16-bit (4 nibble) instance
// and a 4-bit (1 nibble) instance checked against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   last_exp_sum = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
   nibble_serial_adder_if #(.NIBBLES(1)) if1 ();

   nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   // Reference: plain integer addition, signed range test for overflow.
   function automatic void ref_add(input int w, input int a, input int b, input int ci,
                                   output int s, output int co, output int ov);
      int full, sa, sb, ts;
      full = a + b + ci;
      s    = full % (1 << w);
      co   = full >> w;
      sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      ts   = sa + sb + ci;
      ov   = ((ts > (1 << (w - 1)) - 1) || (ts < -(1 << (w - 1)))) ? 1 : 0;
   endfunction

   // Stimulus helpers: one operation, returns latency and outputs; entered and left just after an edge, DUT idle.
   task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          output int lat, output logic [15:0] s, output logic co,
                          output logic ov, output logic done_after);
      if4.a = a; if4.b = b; if4.c_in = ci; if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      if4.a = 16'($urandom); if4.b = 16'($urandom); if4.c_in = 1'($urandom);
      lat = 0;
      while (!if4.done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      s = if4.sum; co = if4.c_out; ov = if4.ovf;
      @(posedge clk); #1;
      done_after = if4.done;
   endtask

   task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic ci,
                          output int lat, output logic [3:0] s, output logic co,
                          output logic ov);
      if1.a = a; if1.b = b; if1.c_in = ci; if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      if1.a = 4'($urandom); if1.b = 4'($urandom); if1.c_in = 1'($urandom);
      lat = 0;
      while (!if1.done && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      s = if1.sum; co = if1.c_out; ov = if1.ovf;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_checks++; if (if4.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready4: got %b want 1", if4.ready); end
      n_checks++; if (if4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", if4.busy); end
      n_checks++; if (if4.done !== 1'b0) begin n_fail++; $display("FAIL reset_done4: got %b want 0", if4.done); end
      n_checks++; if (if4.sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum4: got %h want 0000", if4.sum); end
      n_checks++; if (if4.c_out !== 1'b0) begin n_fail++; $display("FAIL reset_cout4: got %b want 0", if4.c_out); end
      n_checks++; if (if4.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf4: got %b want 0", if4.ovf); end
      n_checks++; if (if1.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", if1.ready); end
      n_checks++; if (if1.sum !== 4'h0) begin n_fail++; $display("FAIL reset_sum1: got %h want 0", if1.sum); end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (if4.ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready4: got %b want 1", if4.ready); end
   endtask

   task automatic test_directed();
      logic [15:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
      logic [15:0] vb [4] = '{16'h0001, 16'h0000, 16'h0001, 16'h8000};
      logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] es [4] = '{16'h0100, 16'h0000, 16'h8000, 16'h0000};
      logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int lat; logic [15:0] s; logic co, ov, da;
      for (int i = 0; i < 4; i++) begin
         run_op4(va[i], vb[i], vc[i], lat, s, co, ov, da);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat); end
         n_checks++; if (s !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, s, es[i]); end
         n_checks++; if (co !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, co, ec[i]); end
         n_checks++; if (ov !== eo[i]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b want %b", i, ov, eo[i]); end
         n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, da); end
         n_checks++; if (if4.ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready_back: got %b want 1", i, if4.ready); end
         last_exp_sum = int'(es[i]);
      end
   endtask

   task automatic test_random();
      int lat, es, ec, eo; logic [15:0] a, b, s; logic ci, co, ov, da;
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
         if (i == 0) begin a = 16'h8001; b = 16'h7FFF; end
         run_op4(a, b, ci, lat, s, co, ov, da);
         ref_add(16, int'(a), int'(b), int'(ci), es, ec, eo);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want 4", i, lat); end
         n_checks++; if (s !== 16'(es)) begin n_fail++; $display("FAIL rnd%0d_sum: a=%h b=%h ci=%b got %h want %h", i, a, b, ci, s, 16'(es)); end
         n_checks++; if (co !== 1'(ec)) begin n_fail++; $display("FAIL rnd%0d_cout: got %b want %0d", i, co, ec); end
         n_checks++; if (ov !== 1'(eo)) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b want %0d", i, ov, eo); end
         last_exp_sum = es;
      end
   endtask

   task automatic test_back_to_back();
      int q_s[$], q_c[$], q_o[$];
      int es, ec, eo, held, ph;
      held = last_exp_sum;
      for (int c = 0; c < 30; c++) begin
         ph = c % 6;
         if4.a = 16'($urandom); if4.b = 16'($urandom); if4.c_in = 1'($urandom);
         if4.start = 1'b1;
         if (ph == 0) begin
            ref_add(16, int'(if4.a), int'(if4.b), int'(if4.c_in), es, ec, eo);
            q_s.push_back(es); q_c.push_back(ec); q_o.push_back(eo);
         end
         @(posedge clk); #1;
         n_checks++; if (if4.done !== (ph == 4)) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b want %b", c, if4.done, (ph == 4)); end
         n_checks++; if (if4.ready !== (ph == 5)) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, if4.ready, (ph == 5)); end
         n_checks++; if (if4.busy !== (ph != 5)) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, if4.busy, (ph != 5)); end
         if (ph == 4) begin
            if (q_s.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL b2b_queue c=%0d: got empty want entry", c);
            end else begin
               es = q_s.pop_front(); ec = q_c.pop_front(); eo = q_o.pop_front();
               held = es;
               n_checks++; if (if4.sum !== 16'(es)) begin n_fail++; $display("FAIL b2b_sum c=%0d: got %h want %h", c, if4.sum, 16'(es)); end
               n_checks++; if (if4.c_out !== 1'(ec)) begin n_fail++; $display("FAIL b2b_cout c=%0d: got %b want %0d", c, if4.c_out, ec); end
               n_checks++; if (if4.ovf !== 1'(eo)) begin n_fail++; $display("FAIL b2b_ovf c=%0d: got %b want %0d", c, if4.ovf, eo); end
            end
         end else begin
            n_checks++; if (if4.sum !== 16'(held)) begin n_fail++; $display("FAIL b2b_sum_hold c=%0d: got %h want %h", c, if4.sum, 16'(held)); end
         end
      end
      if4.start = 1'b0;
      last_exp_sum = held;
   endtask

   task automatic test_abort();
      int lat, es, ec, eo, seen; logic [15:0] a, b, s; logic ci, co, ov, da;
      run_op4(16'h1234, 16'h1111, 1'b0, lat, s, co, ov, da);
      n_checks++; if (s !== 16'h2345) begin n_fail++; $display("FAIL abort_pre_sum: got %h want 2345", s); end
      if4.a = 16'hABCD; if4.b = 16'h4321; if4.c_in = 1'b1; if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++; if (if4.sum !== 16'h0000) begin n_fail++; $display("FAIL abort_sum: got %h want 0000", if4.sum); end
      n_checks++; if (if4.c_out !== 1'b0) begin n_fail++; $display("FAIL abort_cout: got %b want 0", if4.c_out); end
      n_checks++; if (if4.ovf !== 1'b0) begin n_fail++; $display("FAIL abort_ovf: got %b want 0", if4.ovf); end
      n_checks++; if (if4.done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", if4.done); end
      n_checks++; if (if4.ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", if4.ready); end
      n_checks++; if (if4.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", if4.busy); end
      #2 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (if4.done === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      run_op4(a, b, ci, lat, s, co, ov, da);
      ref_add(16, int'(a), int'(b), int'(ci), es, ec, eo);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 4", lat); end
      n_checks++; if (s !== 16'(es)) begin n_fail++; $display("FAIL abort_next_sum: got %h want %h", s, 16'(es)); end
      n_checks++; if (co !== 1'(ec)) begin n_fail++; $display("FAIL abort_next_cout: got %b want %0d", co, ec); end
      n_checks++; if (ov !== 1'(eo)) begin n_fail++; $display("FAIL abort_next_ovf: got %b want %0d", ov, eo); end
   endtask

   task automatic test_nibble1();
      int lat, es, ec, eo; logic [3:0] s; logic co, ov;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               run_op1(4'(a), 4'(b), 1'(ci), lat, s, co, ov);
               ref_add(4, a, b, ci, es, ec, eo);
               n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL n1_latency a=%0d b=%0d ci=%0d: got %0d want 1", a, b, ci, lat); end
               n_checks++; if (s !== 4'(es)) begin n_fail++; $display("FAIL n1_sum a=%0d b=%0d ci=%0d: got %h want %h", a, b, ci, s, 4'(es)); end
               n_checks++; if (co !== 1'(ec)) begin n_fail++; $display("FAIL n1_cout a=%0d b=%0d ci=%0d: got %b want %0d", a, b, ci, co, ec); end
               n_checks++; if (ov !== 1'(eo)) begin n_fail++; $display("FAIL n1_ovf a=%0d b=%0d ci=%0d: got %b want %0d", a, b, ci, ov, eo); end
            end
         end
      end
   endtask

   initial begin
      if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.c_in = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_abort();
      test_nibble1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
